matmult_arbiter: RTL and testbench
==================================

MATMULT_ARBITER -- requirements
Module: matmult_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, meaning WAIT cycles without dp_done before an error response.
REQ-002 sys_clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  2  per-requester request; bit i = requester i; held until gnt[i].
REQ-005 ops0  input  16  requester 0 operands {col1,col0,row1,row0}, 4-bit unsigned each.
REQ-006 ops1  input  16  requester 1 operands, same packing.
REQ-007 gnt  output  2  one-hot, one-cycle grant pulse.
REQ-008 dp_ops  output  16  operands driven to the shared matmult datapath.
REQ-009 dp_start  output  1  one-cycle start pulse to the datapath.
REQ-010 dp_done  input  1  datapath completion pulse (calc_done).
REQ-011 dp_result  input  18  datapath result, valid while dp_done=1.
REQ-012 rsp_valid  output  2  one-hot, one-cycle response pulse to the owning requester.
REQ-013 rsp_result  output  18  result returned with rsp_valid.
REQ-014 rsp_err  output  1  qualifies rsp_valid; 1 = timeout, rsp_result=0.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT, RESP; reset state IDLE.
REQ-017 IDLE: if req!=0, pick winner, latch its ops into dp_ops, pulse gnt[winner] next cycle, go ISSUE; else stay.
REQ-018 Arbitration round-robin: both requesting -> requester not last served wins; single requester always wins.
REQ-019 ISSUE: dp_start=1 for exactly this cycle; load timeout counter with TIMEOUT_CYCLES; go WAIT.
REQ-020 dp_ops held constant from ISSUE until return to IDLE.
REQ-021 WAIT: dp_done=1 -> capture dp_result, rsp_err=0, go RESP; dp_done ignored in IDLE, ISSUE and RESP.
REQ-022 WAIT: counter decrements each cycle without dp_done; reaching 0 -> rsp_result=0, rsp_err=1, go RESP.
REQ-023 dp_done and counter-expiry in same cycle: dp_done wins, no error.
REQ-024 RESP: rsp_valid[owner]=1 one cycle with rsp_result/rsp_err; last-served pointer <= owner; go IDLE.
REQ-025 Latency: req sampled in IDLE at cycle N -> gnt and dp_start at N+1 -> earliest dp_done N+2 -> rsp_valid N+3.
REQ-026 req deasserted before grant: request dropped silently; req held after rsp_valid: re-arbitrated as new request.
REQ-027 ops of the losing requester never sampled; non-owner rsp_valid bit stays 0.
REQ-028 rsp_result and rsp_err hold last response value until the next RESP.

Reset
REQ-029 rst=1 at any clock edge, including mid-transaction: state IDLE, gnt=0, dp_start=0, dp_ops=0, rsp_valid=0, rsp_result=0, rsp_err=0, busy=0, counter=0.
REQ-030 Reset sets last-served pointer to requester 1, so requester 0 wins first tie.
REQ-031 In-flight transaction aborted by rst produces no response; a late dp_done is ignored.

Structure
REQ-032 Package matmult_pkg holds state enum, OP_W=16, RES_W=18, requester-id typedef.
REQ-033 Round-robin picker in sub-module matmult_rr_pick (req, last-served in; one-hot winner out); FSM, counter and registers in matmult_arbiter.

Verification
REQ-034 Single req[0], ops0=16'h2143, dp_done two cycles after dp_start with 18'h0001A -> gnt=01 at N+1, dp_start at N+1, rsp_valid=01 with rsp_result=18'h0001A, rsp_err=0.
REQ-035 req=11 held after reset across three transactions -> grant order 0,1,0; dp_ops equals ops of granted requester.
REQ-036 TIMEOUT_CYCLES=4, dp_done never asserted -> rsp_valid after 4 WAIT cycles, rsp_err=1, rsp_result=0.
REQ-037 dp_done on exact expiry cycle -> rsp_err=0, captured result returned.
REQ-038 rst pulsed during WAIT, then dp_done -> all outputs 0, no rsp_valid, busy=0.
REQ-039 req[1] dropped one cycle before grant with req[0] low -> no gnt, FSM remains IDLE.

Source files
------------

// File: rtl/matmult_pkg.sv
// -----------------------------------------------------------------------------
// matmult_pkg
// Shared types and constants for the two-requester matmult arbiter.
//   OP_W        : width of a packed operand bundle {col1,col0,row1,row0}
//   RES_W       : width of a datapath result
//   NUM_REQ     : number of requesters sharing the datapath
//   arb_state_t : arbiter FSM state encoding
//   req_id_t    : requester index
//   req_vec_t   : one bit per requester (request / grant / response vectors)
// -----------------------------------------------------------------------------
package matmult_pkg;

  localparam int OP_W    = 16;
  localparam int RES_W   = 18;
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  typedef logic                 req_id_t;
  typedef logic [NUM_REQ-1:0]   req_vec_t;

  // Expand a requester index into a one-hot vector.
  function automatic req_vec_t id_to_onehot(input req_id_t id);
    req_vec_t v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // Collapse a one-hot vector into a requester index (lowest set bit wins if
  // the vector is not one-hot; the picker never produces that case).
  function automatic req_id_t onehot_to_id(input req_vec_t v);
    req_id_t id;
    id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        id = req_id_t'(i);
      end
    end
    return id;
  endfunction

endpackage

// File: rtl/matmult_rr_pick.sv
// -----------------------------------------------------------------------------
// matmult_rr_pick
// Combinational round-robin picker for two requesters.
//   req         : in  request vector, bit i = requester i
//   last_served : in  index of the requester that received the last response
//   winner      : out one-hot winner, all zeros when nobody requests
// A lone requester always wins; when both request, the one that was not
// served last wins.
// -----------------------------------------------------------------------------
module matmult_rr_pick
  import matmult_pkg::*;
(
  input  req_vec_t req,
  input  req_id_t  last_served,
  output req_vec_t winner
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_pick
      // With two requesters the "other" one is simply the mirror index.
      localparam int OTHER = NUM_REQ - 1 - gi;

      // Requester gi wins when it asks and either the other one is quiet or
      // gi was not the one served last.
      assign winner[gi] = req[gi] &
                          (~req[OTHER] | (last_served != req_id_t'(gi)));
    end
  endgenerate

endmodule

// File: rtl/matmult_arbiter.sv
// -----------------------------------------------------------------------------
// matmult_arbiter
// Shares one matmult datapath between two requesters. A request is sampled in
// IDLE, the winner's operands are latched and issued with a one-cycle start
// pulse, the FSM then waits for the datapath completion (or a timeout) and
// returns a one-cycle response to the owning requester.
//
// Parameters
//   TIMEOUT_CYCLES : WAIT cycles without dp_done before an error response
// Ports
//   sys_clk    : in  clock, all logic on the rising edge
//   rst        : in  synchronous active-high reset
//   req        : in  [2]  per-requester request, held until its grant
//   ops0/ops1  : in  [16] requester operand bundles {col1,col0,row1,row0}
//   gnt        : out [2]  one-hot, one-cycle grant pulse
//   dp_ops     : out [16] operands to the datapath, stable while busy
//   dp_start   : out      one-cycle datapath start pulse
//   dp_done    : in       datapath completion pulse
//   dp_result  : in  [18] datapath result, valid with dp_done
//   rsp_valid  : out [2]  one-hot, one-cycle response pulse
//   rsp_result : out [18] result (0 on timeout), held until next response
//   rsp_err    : out      1 = timeout, held until next response
//   busy       : out      high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module matmult_arbiter
  import matmult_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [OP_W-1:0]  ops0,
  input  logic [OP_W-1:0]  ops1,
  output logic [1:0]       gnt,
  output logic [OP_W-1:0]  dp_ops,
  output logic             dp_start,
  input  logic             dp_done,
  input  logic [RES_W-1:0] dp_result,
  output logic [1:0]       rsp_valid,
  output logic [RES_W-1:0] rsp_result,
  output logic             rsp_err,
  output logic             busy
);

  // Counter wide enough to hold TIMEOUT_CYCLES itself.
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_t       state_reg;
  req_id_t          owner_reg;
  req_id_t          last_served_reg;
  logic [CNT_W-1:0] cnt_reg;

  req_vec_t         winner;
  req_id_t          winner_id;
  logic [OP_W-1:0]  ops_arr [NUM_REQ];
  logic [OP_W-1:0]  winner_ops;

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
  matmult_rr_pick u_pick (
    .req         (req),
    .last_served (last_served_reg),
    .winner      (winner)
  );

  assign ops_arr[0] = ops0;
  assign ops_arr[1] = ops1;

  assign winner_id  = onehot_to_id(winner);
  // Only the winner's bundle is routed to the latch; the loser's operands
  // never reach a register.
  assign winner_ops = ops_arr[winner_id];

  assign busy = (state_reg != ST_IDLE);

  // ---------------------------------------------------------------------------
  // FSM, timeout counter and all registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      owner_reg       <= '0;
      last_served_reg <= req_id_t'(1);   // requester 0 wins the first tie
      cnt_reg         <= '0;
      gnt             <= '0;
      dp_ops          <= '0;
      dp_start        <= 1'b0;
      rsp_valid       <= '0;
      rsp_result      <= '0;
      rsp_err         <= 1'b0;
    end else begin
      // Pulse outputs fall back to zero unless a transition below raises them.
      gnt       <= '0;
      dp_start  <= 1'b0;
      rsp_valid <= '0;

      case (state_reg)
        ST_IDLE: begin
          if (|winner) begin
            // Grant and start are registered here so that both are visible
            // during the ISSUE cycle.
            owner_reg <= winner_id;
            dp_ops    <= winner_ops;
            gnt       <= winner;
            dp_start  <= 1'b1;
            state_reg <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          cnt_reg   <= CNT_LOAD;
          state_reg <= ST_WAIT;
        end

        ST_WAIT: begin
          // Completion is checked first so that a dp_done on the expiry
          // cycle still returns a good result.
          if (dp_done) begin
            rsp_result <= dp_result;
            rsp_err    <= 1'b0;
            rsp_valid  <= id_to_onehot(owner_reg);
            state_reg  <= ST_RESP;
          end else if (cnt_reg <= CNT_ONE) begin
            cnt_reg    <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b1;
            rsp_valid  <= id_to_onehot(owner_reg);
            state_reg  <= ST_RESP;
          end else begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end

        ST_RESP: begin
          // The pointer moves only once a response has gone out, so an
          // aborted transaction does not disturb the fairness order.
          last_served_reg <= owner_reg;
          state_reg       <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_matmult_arbiter
// Directed testbench for matmult_arbiter (TIMEOUT_CYCLES = 4).
// Inputs are driven 1 time unit after each rising edge; outputs are observed
// at the same point, so every observation shows the registers of the cycle
// that has just started.
// -----------------------------------------------------------------------------
module tb_matmult_arbiter;

  localparam int TMO = 4;

  logic        sys_clk;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] ops0;
  logic [15:0] ops1;
  logic [1:0]  gnt;
  logic [15:0] dp_ops;
  logic        dp_start;
  logic        dp_done;
  logic [17:0] dp_result;
  logic [1:0]  rsp_valid;
  logic [17:0] rsp_result;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  matmult_arbiter #(
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .req        (req),
    .ops0       (ops0),
    .ops1       (ops1),
    .gnt        (gnt),
    .dp_ops     (dp_ops),
    .dp_start   (dp_start),
    .dp_done    (dp_done),
    .dp_result  (dp_result),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset;
    rst = 1'b1; req = 2'b00; ops0 = 16'h0; ops1 = 16'h0;
    dp_done = 1'b0; dp_result = 18'h0;
    tick; tick;
    rst = 1'b0;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b want 00", gnt); end
    checks++; if (dp_start !== 1'b0) begin errors++; $display("FAIL reset_dp_start got %b want 0", dp_start); end
    checks++; if (dp_ops !== 16'h0) begin errors++; $display("FAIL reset_dp_ops got %h want 0000", dp_ops); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); end
    checks++; if (rsp_result !== 18'h0) begin errors++; $display("FAIL reset_rsp_result got %h want 00000", rsp_result); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_req_busy got %b want 0", busy); end
    $display("txn reset: done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single;
    req = 2'b01; ops0 = 16'h2143; ops1 = 16'hFFFF;          // cycle N
    tick;                                                    // N+1 (ISSUE)
    req = 2'b00;
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL single_gnt got %b want 01", gnt); end
    checks++; if (dp_start !== 1'b1) begin errors++; $display("FAIL single_dp_start got %b want 1", dp_start); end
    checks++; if (dp_ops !== 16'h2143) begin errors++; $display("FAIL single_dp_ops got %h want 2143", dp_ops); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    tick;                                                    // N+2 (WAIT)
    checks++; if (dp_start !== 1'b0) begin errors++; $display("FAIL single_start_pulse got %b want 0", dp_start); end
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL single_gnt_pulse got %b want 00", gnt); end
    tick;                                                    // N+3
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL single_early_rsp got %b want 00", rsp_valid); end
    dp_done = 1'b1; dp_result = 18'h0001A;
    tick;                                                    // N+4 (RESP)
    dp_done = 1'b0; dp_result = 18'h0;
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL single_rsp_valid got %b want 01", rsp_valid); end
    checks++; if (rsp_result !== 18'h0001A) begin errors++; $display("FAIL single_rsp_result got %h want 0001a", rsp_result); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL single_rsp_err got %b want 0", rsp_err); end
    tick;                                                    // IDLE
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL single_rsp_pulse got %b want 00", rsp_valid); end
    checks++; if (rsp_result !== 18'h0001A) begin errors++; $display("FAIL single_rsp_hold got %h want 0001a", rsp_result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle got %b want 0", busy); end
    $display("txn single: rsp_result=%h rsp_err=%b", rsp_result, rsp_err);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_round_robin;
    logic [1:0]  exp_gnt [3];
    logic [15:0] exp_ops [3];
    logic [17:0] res;
    int          k;
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01;
    exp_ops[0] = 16'hA1B2; exp_ops[1] = 16'hC3D4; exp_ops[2] = 16'hA1B2;
    rst = 1'b1;
    tick;
    rst = 1'b0; req = 2'b11; ops0 = 16'hA1B2; ops1 = 16'hC3D4;
    for (int t = 0; t < 3; t++) begin
      k = 0;
      tick;
      while (gnt === 2'b00 && k < 8) begin
        tick;
        k++;
      end
      checks++;
      if (gnt !== exp_gnt[t]) begin
        errors++; $display("FAIL rr_gnt_%0d got %b want %b", t, gnt, exp_gnt[t]);
      end
      checks++;
      if (dp_ops !== exp_ops[t]) begin
        errors++; $display("FAIL rr_dp_ops_%0d got %h want %h", t, dp_ops, exp_ops[t]);
      end
      tick;                                                  // WAIT
      res = 18'(256 + t);
      dp_done = 1'b1; dp_result = res;
      tick;                                                  // RESP
      dp_done = 1'b0;
      checks++;
      if (rsp_valid !== exp_gnt[t] || rsp_result !== res) begin
        errors++; $display("FAIL rr_rsp_%0d got %b/%h want %b/%h", t, rsp_valid, rsp_result, exp_gnt[t], res);
      end
      $display("txn rr %0d: gnt=%b dp_ops=%h rsp=%h", t, gnt, dp_ops, rsp_result);
    end
    req = 2'b00;
    tick;                                                    // IDLE
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_timeout;
    int n;
    req = 2'b10; ops1 = 16'h5A5A; dp_result = 18'h3FFFF;     // result never qualified
    tick;                                                    // ISSUE
    req = 2'b00;
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL tmo_gnt got %b want 10", gnt); end
    checks++; if (dp_ops !== 16'h5A5A) begin errors++; $display("FAIL tmo_dp_ops got %h want 5a5a", dp_ops); end
    n = 0;
    while (rsp_valid === 2'b00 && n < 20) begin
      tick;
      n++;
    end
    // ISSUE -> 4 WAIT cycles -> RESP is 5 cycles after the grant.
    checks++; if (n != 5) begin errors++; $display("FAIL tmo_latency got %0d want 5", n); end
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL tmo_rsp_valid got %b want 10", rsp_valid); end
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL tmo_rsp_err got %b want 1", rsp_err); end
    checks++; if (rsp_result !== 18'h0) begin errors++; $display("FAIL tmo_rsp_result got %h want 00000", rsp_result); end
    dp_result = 18'h0;
    tick;                                                    // IDLE
    $display("txn timeout: cycles=%0d rsp_err=%b", n, rsp_err);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_exact_expiry;
    req = 2'b01; ops0 = 16'h1234;
    tick;                                                    // ISSUE
    req = 2'b00;
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL exp_gnt got %b want 01", gnt); end
    tick; tick; tick; tick;                                  // WAIT 1..4
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL exp_early_rsp got %b want 00", rsp_valid); end
    dp_done = 1'b1; dp_result = 18'h2A5C3;
    tick;                                                    // RESP
    dp_done = 1'b0; dp_result = 18'h0;
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL exp_rsp_valid got %b want 01", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL exp_rsp_err got %b want 0", rsp_err); end
    checks++; if (rsp_result !== 18'h2A5C3) begin errors++; $display("FAIL exp_rsp_result got %h want 2a5c3", rsp_result); end
    tick;                                                    // IDLE
    $display("txn exact_expiry: rsp_result=%h rsp_err=%b", rsp_result, rsp_err);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid;
    int stray;
    req = 2'b01; ops0 = 16'h0F0F;
    tick;                                                    // ISSUE
    req = 2'b00;
    tick;                                                    // WAIT
    rst = 1'b1;
    tick;                                                    // reset applied
    rst = 1'b0; dp_done = 1'b1; dp_result = 18'h12345;       // late completion
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rstmid_gnt got %b want 00", gnt); end
    checks++; if (dp_start !== 1'b0) begin errors++; $display("FAIL rstmid_dp_start got %b want 0", dp_start); end
    checks++; if (dp_ops !== 16'h0) begin errors++; $display("FAIL rstmid_dp_ops got %h want 0000", dp_ops); end
    checks++; if (rsp_result !== 18'h0) begin errors++; $display("FAIL rstmid_rsp_result got %h want 00000", rsp_result); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rstmid_rsp_err got %b want 0", rsp_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    tick;
    dp_done = 1'b0; dp_result = 18'h0;
    stray = 0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid !== 2'b00 || busy !== 1'b0) stray++;
      tick;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL rstmid_no_rsp got %0d stray cycles want 0", stray); end
    $display("txn reset_mid: aborted");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_drop;
    req = 2'b01; ops0 = 16'h7777; ops1 = 16'h8888;
    tick;                                                    // ISSUE
    req = 2'b10;                                             // req[1] arrives while busy
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL drop_gnt0 got %b want 01", gnt); end
    tick;                                                    // WAIT
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL drop_busy_gnt got %b want 00", gnt); end
    dp_done = 1'b1; dp_result = 18'h00055;
    tick;                                                    // RESP
    dp_done = 1'b0; dp_result = 18'h0;
    req = 2'b00;                                             // dropped before any grant
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL drop_rsp_owner got %b want 01", rsp_valid); end
    tick;                                                    // IDLE
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle_busy got %b want 0", busy); end
    tick;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL drop_no_gnt got %b want 00", gnt); end
    checks++; if (busy !== 1'b0 || dp_start !== 1'b0) begin errors++; $display("FAIL drop_stay_idle got busy=%b start=%b want 0/0", busy, dp_start); end
    $display("txn drop: no grant issued");
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_timeout;
    test_exact_expiry;
    test_reset_mid;
    test_drop;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
